// File: rtl/mult_pkg.sv
// mult_pkg: shared types and helpers for the sequential shift-add multiplier.
//   state_t : FSM encoding (IDLE=0, CALC=1, DONE=2)
//   clog2   : width of the step counter for a given operand WIDTH
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..value-1; never less than 1 so a counter always exists.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mult_sign_cond.sv
// mult_sign_cond: two's-complement conditioning for the signed multiplier build.
//   a, b      in  WIDTH    raw signed operands
//   acc       in  2*WIDTH  unsigned magnitude product (final step value)
//   neg_acc   in  1        registered sign of the operation in flight
//   mag_a     out WIDTH    |a| as unsigned (|-2^(WIDTH-1)| fits)
//   mag_b     out WIDTH    |b| as unsigned
//   neg       out 1        sign of a*b, to be latched at accept
//   result    out 2*WIDTH  neg_acc ? -acc : acc
module mult_sign_cond #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] acc,
  input  logic               neg_acc,
  output logic [WIDTH-1:0]   mag_a,
  output logic [WIDTH-1:0]   mag_b,
  output logic               neg,
  output logic [2*WIDTH-1:0] result
);

  always_comb begin
    mag_a  = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    mag_b  = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    neg    = a[WIDTH-1] ^ b[WIDTH-1];
    result = neg_acc ? (~acc + (2*WIDTH)'(1)) : acc;
  end

endmodule

// File: rtl/multiplier_seq.sv
// multiplier_seq: sequential shift-add multiplier, one multiplier bit per clock.
// Build option: define MULT_SIGNED_EN for two's-complement operands/product
// (instantiates mult_sign_cond); undefined gives unsigned-only logic.
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous reset, active-high
//   in_valid   in   1        a/b valid
//   in_ready   out  1        operands accepted (IDLE only)
//   a          in   WIDTH    multiplicand
//   b          in   WIDTH    multiplier
//   out_valid  out  1        product valid (DONE)
//   out_ready  in   1        downstream takes product
//   product    out  2*WIDTH  a*b, held until taken
//   busy       out  1        state != IDLE
// Latency: accept on edge E, out_valid from edge E+WIDTH regardless of operands.
module multiplier_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned CW = clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  state_t            state, state_next;
  logic [WIDTH-1:0]  mcand, mplier;
  logic [PW-1:0]     acc, acc_step, result;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  op_a, op_b;
  logic              last_step;

  // The final step's sum goes straight to product, so the step that
  // consumes the top multiplier bit also completes the operation.
  always_comb begin
    acc_step  = acc + (mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0);
    last_step = (cnt == CW'(WIDTH - 1));
  end

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_in;

  mult_sign_cond #(.WIDTH(WIDTH)) u_sign (
    .a       (a),
    .b       (b),
    .acc     (acc_step),
    .neg_acc (neg_q),
    .mag_a   (op_a),
    .mag_b   (op_b),
    .neg     (neg_in),
    .result  (result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      neg_q <= neg_in;
    end
  end
`else
  always_comb begin
    op_a   = a;
    op_b   = b;
    result = acc_step;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc_step;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last_step) product <= result;
        end
        default: ;
      endcase
    end
  end

endmodule
